// File: rtl/seq_detect_param_if.sv
// Serial detector bus: qualified data bit in, runtime config in, match flag/stats out.
// master drives din_valid/din and the cfg_* fields; slave (the detector) drives dout/match_cnt/fill.
// Ports: din_valid, din, cfg_load, cfg_pat, cfg_len, cfg_ovl -> slave; dout, match_cnt, fill -> master.
interface seq_detect_param_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             din_valid;
  logic             din;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_ovl;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;
  logic [LEN_W-1:0] fill;

  modport master (
    output din_valid, din, cfg_load, cfg_pat, cfg_len, cfg_ovl,
    input  dout, match_cnt, fill
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pat, cfg_len, cfg_ovl,
    output dout, match_cnt, fill
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-pattern detector with saturating match counter.
// Latency: dout same cycle as the matching bit (Mealy); one cycle later when SEQDET_REG_OUT_EN is defined.
// Backpressure: none; a bit is consumed every cycle din_valid=1, cfg_load wins over din_valid.
// Ports: clk, reset (sync, active-low), bus (seq_detect_param_if.slave: din_valid/din in,
//        cfg_load/cfg_pat/cfg_len/cfg_ovl in, dout/match_cnt/fill out).
// Optional feature macro: SEQDET_REG_OUT_EN (registered dout).
module seq_detect_param #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'('h0D),
  parameter int               DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               reset,
  seq_detect_param_if.slave  bus
);
  localparam int               LEN_W     = $clog2(PAT_W + 1);
  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

  // History keeps only PAT_W-1 bits: the window's newest bit is always din itself.
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] cfg_len_clamped;
  logic             fill_ok;
  logic             match;

  // Oversized lengths are clamped once at load so len_q is always 0..PAT_W.
  assign cfg_len_clamped = (bus.cfg_len > PAT_W_L) ? PAT_W_L : bus.cfg_len;

  always_comb begin
    win = {hist_q, bus.din};
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    // fill >= L-1 evaluated as fill+1 >= L, one bit wider to avoid underflow at L=0.
    fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
    // reset/cfg_load gate the flag so dout is quiet in those cycles.
    match = reset && !bus.cfg_load && bus.din_valid && fill_ok &&
            (len_q != '0) && (((win ^ pat_q) & mask) == '0);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    if (bus.cfg_load) begin
      pat_d  = bus.cfg_pat;
      len_d  = cfg_len_clamped;
      ovl_d  = bus.cfg_ovl;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.din_valid) begin
      if (match && !ovl_q) begin
        // Non-overlapping: no bit of the matched window may seed the next match.
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = win[PAT_W-2:0];
        fill_d = (fill_q == PAT_W_L) ? fill_q : fill_q + LEN_W'(1);
      end
      if (match && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= DEF_LEN_L;
      ovl_q  <= 1'b1;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
    end
  end

`ifdef SEQDET_REG_OUT_EN
  logic dout_q, dout_d;

  // match is already forced low by cfg_load, so only reset needs explicit clearing.
  assign dout_d = match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign bus.dout = dout_q;
`else
  assign bus.dout = match;
`endif

  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;
endmodule
